// File: rtl/median_window_gen.sv
// median_window_gen: raster pixel stream -> 3x3 window feeder for the median
// comparator network. Two line buffers supply the upper rows; each complete
// window is held steady while the comparator is stepped through its three
// stages, and the returned median is emitted as a one-cycle output pulse.
module median_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid,
    input  logic       pixel_sof,
    output logic       pixel_ready,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic [7:0] in3,
    output logic [7:0] in4,
    output logic [7:0] in5,
    output logic [7:0] in6,
    output logic [7:0] in7,
    output logic [7:0] in8,
    output logic [7:0] in9,
    output logic       ldFilter,
    output logic [1:0] selFilter,
    input  logic [7:0] med_in,
    output logic [7:0] pix_out,
    output logic       pix_out_valid,
    output logic       pix_out_last
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned TAPS  = 9;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1   = 3'd1;
    localparam logic [2:0] ST_S2   = 3'd2;
    localparam logic [2:0] ST_S3   = 3'd3;
    localparam logic [2:0] ST_S4   = 3'd4;

    // Line buffers: lb0 holds row r-2, lb1 holds row r-1 for the current column.
    logic [PIX_W-1:0] lb0_mem [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_mem [IMG_WIDTH];

    logic [2:0]            state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [TAPS-1:0][PIX_W-1:0] win_q, win_d;   // index = row*3 + col
    logic                  last_pend_q, last_pend_d;
    logic                  pixel_ready_q, pixel_ready_d;
    logic                  ld_filter_q, ld_filter_d;
    logic [1:0]            sel_filter_q, sel_filter_d;
    logic [PIX_W-1:0]      pix_out_q, pix_out_d;
    logic                  pix_out_valid_q, pix_out_valid_d;
    logic                  pix_out_last_q, pix_out_last_d;

    logic                  accept_c;
    logic [COL_W-1:0]      col_eff_c;
    logic [ROW_W-1:0]      row_eff_c;
    logic [PIX_W-1:0]      top_c;
    logic [PIX_W-1:0]      mid_c;
    logic                  col_last_c;
    logic                  row_last_c;
    logic                  win_valid_c;

    // Accept qualification and effective position (start-of-frame forces 0,0).
    always_comb begin
        accept_c    = pixel_valid && pixel_ready_q;
        col_eff_c   = pixel_sof ? '0 : col_q;
        row_eff_c   = pixel_sof ? '0 : row_q;
        top_c       = lb0_mem[col_eff_c];
        mid_c       = lb1_mem[col_eff_c];
        col_last_c  = (col_eff_c == COL_W'(IMG_WIDTH - 1));
        row_last_c  = (row_eff_c == ROW_W'(IMG_HEIGHT - 1));
        win_valid_c = (row_eff_c >= ROW_W'(2)) && (col_eff_c >= COL_W'(2));
    end

    // Next-state, counters, window shift and registered-output decode.
    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        win_d           = win_q;
        last_pend_d     = last_pend_q;
        pix_out_d       = pix_out_q;
        pix_out_valid_d = 1'b0;
        pix_out_last_d  = 1'b0;
        pixel_ready_d   = 1'b0;
        ld_filter_d     = 1'b0;
        sel_filter_d    = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r*3 + 0] = win_q[r*3 + 1];
                        win_d[r*3 + 1] = win_q[r*3 + 2];
                    end
                    win_d[2] = top_c;
                    win_d[5] = mid_c;
                    win_d[8] = pixel_in;

                    if (col_last_c) begin
                        col_d = '0;
                        row_d = row_last_c ? '0 : row_eff_c + ROW_W'(1);
                    end else begin
                        col_d = col_eff_c + COL_W'(1);
                        row_d = row_eff_c;
                    end

                    if (win_valid_c) begin
                        state_d     = ST_S1;
                        last_pend_d = row_last_c && col_last_c;
                    end
                end
            end
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_S4;
            ST_S4: begin
                pix_out_d       = med_in;
                pix_out_valid_d = 1'b1;
                pix_out_last_d  = last_pend_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Comparator controls and ready follow the state being entered.
        case (state_d)
            ST_IDLE: pixel_ready_d = 1'b1;
            ST_S1: begin
                ld_filter_d  = 1'b1;
                sel_filter_d = 2'd1;
            end
            ST_S2: begin
                ld_filter_d  = 1'b1;
                sel_filter_d = 2'd2;
            end
            ST_S3: begin
                ld_filter_d  = 1'b1;
                sel_filter_d = 2'd3;
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            col_q           <= '0;
            row_q           <= '0;
            win_q           <= '0;
            last_pend_q     <= 1'b0;
            pixel_ready_q   <= 1'b1;
            ld_filter_q     <= 1'b0;
            sel_filter_q    <= 2'd0;
            pix_out_q       <= '0;
            pix_out_valid_q <= 1'b0;
            pix_out_last_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            win_q           <= win_d;
            last_pend_q     <= last_pend_d;
            pixel_ready_q   <= pixel_ready_d;
            ld_filter_q     <= ld_filter_d;
            sel_filter_q    <= sel_filter_d;
            pix_out_q       <= pix_out_d;
            pix_out_valid_q <= pix_out_valid_d;
            pix_out_last_q  <= pix_out_last_d;
        end
    end

    // Line-buffer update on accept; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb0_mem[col_eff_c] <= mid_c;
            lb1_mem[col_eff_c] <= pixel_in;
        end
    end

    assign pixel_ready   = pixel_ready_q;
    assign ldFilter      = ld_filter_q;
    assign selFilter     = sel_filter_q;
    assign pix_out       = pix_out_q;
    assign pix_out_valid = pix_out_valid_q;
    assign pix_out_last  = pix_out_last_q;

    assign in1 = win_q[0];
    assign in2 = win_q[1];
    assign in3 = win_q[2];
    assign in4 = win_q[3];
    assign in5 = win_q[4];
    assign in6 = win_q[5];
    assign in7 = win_q[6];
    assign in8 = win_q[7];
    assign in9 = win_q[8];

endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: directed bench for a 4x4 frame with a behavioural
// three-stage median comparator attached to the window taps.
module tb_median_window_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       pixel_valid = 1'b0;
    logic       pixel_sof = 1'b0;
    logic       pixel_ready;
    logic [7:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
    logic       ldFilter;
    logic [1:0] selFilter;
    logic [7:0] med_in;
    logic [7:0] pix_out;
    logic       pix_out_valid;
    logic       pix_out_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] taps [9];
    logic [7:0] outs [$];
    bit         lasts [$];

    median_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_sof(pixel_sof),
        .pixel_ready(pixel_ready),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .in6(in6), .in7(in7), .in8(in8), .in9(in9),
        .ldFilter(ldFilter), .selFilter(selFilter), .med_in(med_in),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_last(pix_out_last)
    );

    always #5 clk = ~clk;

    assign taps[0] = in1; assign taps[1] = in2; assign taps[2] = in3;
    assign taps[3] = in4; assign taps[4] = in5; assign taps[5] = in6;
    assign taps[6] = in7; assign taps[7] = in8; assign taps[8] = in9;

    function automatic logic [7:0] median9(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    // Comparator model: median only appears if stages 1,2,3 arrive in order.
    int         stg = 0;
    logic [7:0] med_r = '0;
    assign med_in = med_r;
    always @(posedge clk) begin
        if (!rst_n) stg <= 0;
        else if (ldFilter) begin
            if (int'(selFilter) == stg + 1) stg <= stg + 1;
            else stg <= 0;
            if (selFilter == 2'd3 && stg == 2) med_r <= median9(taps);
        end else stg <= 0;
    end

    // Output monitor.
    always @(negedge clk) begin
        if (pix_out_valid) begin
            outs.push_back(pix_out);
            lasts.push_back(pix_out_last);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one pixel from a negedge and returns after the accepting posedge.
    task automatic push_pixel(input logic [7:0] p, input bit sof, input bit bubbles);
        int guard;
        if (bubbles) begin
            pixel_valid = 1'b0;
            idle_cycles($urandom_range(0, 2));
        end
        pixel_in    = p;
        pixel_sof   = sof;
        pixel_valid = 1'b1;
        guard = 0;
        while (!pixel_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    // Pixel-10 handshake and tap timing around an accept at cycle T.
    task automatic check_timing();
        logic [7:0] exp_taps [9];
        exp_taps = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                check($sformatf("ready_T%0d", k), int'(pixel_ready), 0);
                check($sformatf("ld_T%0d", k), int'(ldFilter), 1);
                check($sformatf("sel_T%0d", k), int'(selFilter), k);
                for (int i = 0; i < 9; i++)
                    check($sformatf("tap%0d_T%0d", i + 1, k), int'(taps[i]), int'(exp_taps[i]));
            end else if (k == 4) begin
                check("ready_T4", int'(pixel_ready), 0);
                check("ld_T4", int'(ldFilter), 0);
                check("valid_T4", int'(pix_out_valid), 0);
            end else begin
                check("valid_T5", int'(pix_out_valid), 1);
                check("pix_out_T5", int'(pix_out), 5);
                check("ready_T5", int'(pixel_ready), 1);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] px [16], input int n,
                              input bit bubbles, input bit timing);
        for (int i = 0; i < n; i++) begin
            push_pixel(px[i], i == 0, bubbles);
            if (timing && i == 10) check_timing();
        end
        idle_cycles(10);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] exp [4]);
        check({tag, "_count"}, outs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_val%0d", tag, i),
                  (i < outs.size()) ? int'(outs[i]) : -1, int'(exp[i]));
            check($sformatf("%s_last%0d", tag, i),
                  (i < lasts.size()) ? int'(lasts[i]) : -1, (i == 3) ? 1 : 0);
        end
        outs.delete();
        lasts.delete();
    endtask

    initial begin
        logic [7:0] ramp [16];
        logic [7:0] imp  [16];
        logic [7:0] exp_ramp [4];
        logic [7:0] exp_imp  [4];
        int guard;

        for (int i = 0; i < 16; i++) begin
            ramp[i] = 8'(i);
            imp[i]  = (i == 5) ? 8'd255 : 8'd50;
        end
        exp_ramp = '{8'd5, 8'd6, 8'd9, 8'd10};
        exp_imp  = '{8'd50, 8'd50, 8'd50, 8'd50};

        // 1: reset then idle
        idle_cycles(3);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle_cycles(3);
            check("rst_ready", int'(pixel_ready), 1);
            check("rst_ld", int'(ldFilter), 0);
            check("rst_sel", int'(selFilter), 0);
            check("rst_valid", int'(pix_out_valid), 0);
        end
        check("rst_pix_out", int'(pix_out), 0);
        check("rst_last", int'(pix_out_last), 0);
        check("rst_in1", int'(in1), 0);
        check("rst_in9", int'(in9), 0);

        // 2 + 3: ramp frame with timing around pixel 10
        send_frame(ramp, 16, 1'b0, 1'b1);
        check_outputs("ramp", exp_ramp);

        // 4: impulse removal
        send_frame(imp, 16, 1'b0, 1'b0);
        check_outputs("impulse", exp_imp);

        // 5: partial frame then restart, then repeat with bubbles
        send_frame(imp, 6, 1'b0, 1'b0);
        send_frame(ramp, 16, 1'b0, 1'b0);
        check_outputs("restart", exp_ramp);
        send_frame(imp, 6, 1'b1, 1'b0);
        send_frame(ramp, 16, 1'b1, 1'b0);
        check_outputs("bubbles", exp_ramp);

        // 6: reset while in S2
        for (int i = 0; i < 10; i++) push_pixel(ramp[i], i == 0, 1'b0);
        idle_cycles(8);
        outs.delete();
        lasts.delete();
        @(negedge clk);
        pixel_in = 8'd10; pixel_valid = 1'b1;
        guard = 0;
        while (!pixel_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 pixel_valid = 1'b0;
        @(negedge clk);                       // S1
        check("pre_rst_sel1", int'(selFilter), 1);
        @(negedge clk);                       // S2
        check("pre_rst_sel2", int'(selFilter), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ld", int'(ldFilter), 0);
        check("midrst_sel", int'(selFilter), 0);
        check("midrst_ready", int'(pixel_ready), 1);
        idle_cycles(8);
        check("midrst_no_out", outs.size(), 0);
        send_frame(ramp, 16, 1'b0, 1'b0);
        check_outputs("after_rst", exp_ramp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
